// File: rtl/geri_yaz_pkg.sv
// rtl/geri_yaz_pkg.sv - shared constants, uop field layout and FSM encoding for the writeback stage
package geri_yaz_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int VERI_BIT = 32;

  // Load funct3 codes carried in UOP_BEL_TUR
  localparam logic [2:0] TUR_LB  = 3'b000;
  localparam logic [2:0] TUR_LH  = 3'b001;
  localparam logic [2:0] TUR_LW  = 3'b010;
  localparam logic [2:0] TUR_LBU = 3'b100;
  localparam logic [2:0] TUR_LHU = 3'b101;

  // Uop bus layout: {VALID, RD[4:0], RD_YAZ, BEL_OKU, BEL_TUR[2:0], BEL_LSB[1:0], DEGER[31:0]}
  localparam int UOP_DEGER_LSB = 0;
  localparam int UOP_DEGER_MSB = 31;
  localparam int UOP_LSB_LSB   = 32;
  localparam int UOP_LSB_MSB   = 33;
  localparam int UOP_TUR_LSB   = 34;
  localparam int UOP_TUR_MSB   = 36;
  localparam int UOP_BEL_OKU   = 37;
  localparam int UOP_RD_YAZ    = 38;
  localparam int UOP_RD_LSB    = 39;
  localparam int UOP_RD_MSB    = 43;
  localparam int UOP_VALID     = 44;
  localparam int UOP_BIT       = 45;

  typedef enum logic {
    BOSTA      = 1'b0,
    VERI_BEKLE = 1'b1
  } durum_e;

  // Fields of a load kept while its read data is outstanding
  typedef struct packed {
    logic [4:0] rd;
    logic       rd_yaz;
    logic [2:0] tur;
    logic [1:0] lsb;
  } yakalanan_t;

endpackage

// File: rtl/geri_yaz_yukleme_hizalayici.sv
// rtl/geri_yaz_yukleme_hizalayici.sv - load data lane select, sign/zero extension and misalignment detect
module geri_yaz_yukleme_hizalayici
  import geri_yaz_pkg::*;
(
  input  logic [VERI_BIT-1:0] kelime_i,
  input  logic [2:0]          tur_i,
  input  logic [1:0]          lsb_i,
  output logic [VERI_BIT-1:0] sonuc_o,
  output logic                hizasiz_o
);

  logic [7:0]  bayt;
  logic [15:0] yarim;

  // Pick the addressed byte/half lane and extend it according to the load type
  always_comb begin
    case (lsb_i)
      2'd0:    bayt = kelime_i[7:0];
      2'd1:    bayt = kelime_i[15:8];
      2'd2:    bayt = kelime_i[23:16];
      default: bayt = kelime_i[31:24];
    endcase
    yarim     = lsb_i[1] ? kelime_i[31:16] : kelime_i[15:0];
    sonuc_o   = kelime_i;
    hizasiz_o = LOW;
    case (tur_i)
      TUR_LB:  sonuc_o = {{24{bayt[7]}}, bayt};
      TUR_LBU: sonuc_o = {24'h0, bayt};
      TUR_LH: begin
        sonuc_o   = {{16{yarim[15]}}, yarim};
        hizasiz_o = lsb_i[0];
      end
      TUR_LHU: begin
        sonuc_o   = {16'h0, yarim};
        hizasiz_o = lsb_i[0];
      end
      // LW and every unlisted code behave as a full-word load
      default: begin
        sonuc_o   = kelime_i;
        hizasiz_o = (lsb_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/geri_yaz.sv
// rtl/geri_yaz.sv - writeback stage: load wait FSM, register-file write port, retire counter
module geri_yaz
  import geri_yaz_pkg::*;
#(
  parameter int SAYAC_BIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [UOP_BIT-1:0]   bellek_uop_i,
  input  logic [VERI_BIT-1:0]  l1v_veri_i,
  input  logic                 l1v_veri_gecerli_i,
  output logic                 l1v_veri_hazir_o,
  output logic                 duraklat_o,
  output logic                 yaz_gecerli_o,
  output logic [4:0]           yaz_adres_o,
  output logic [VERI_BIT-1:0]  yaz_veri_o,
  output logic                 hata_o,
  output logic                 emekli_o,
  output logic [SAYAC_BIT-1:0] emekli_sayac_o
);

  logic                uop_valid, uop_rd_yaz, uop_oku;
  logic [4:0]          uop_rd;
  logic [2:0]          uop_tur;
  logic [1:0]          uop_lsb;
  logic [VERI_BIT-1:0] uop_deger;

  assign uop_valid  = bellek_uop_i[UOP_VALID];
  assign uop_rd     = bellek_uop_i[UOP_RD_MSB:UOP_RD_LSB];
  assign uop_rd_yaz = bellek_uop_i[UOP_RD_YAZ];
  assign uop_oku    = bellek_uop_i[UOP_BEL_OKU];
  assign uop_tur    = bellek_uop_i[UOP_TUR_MSB:UOP_TUR_LSB];
  assign uop_lsb    = bellek_uop_i[UOP_LSB_MSB:UOP_LSB_LSB];
  assign uop_deger  = bellek_uop_i[UOP_DEGER_MSB:UOP_DEGER_LSB];

  durum_e              durum_q, durum_d;
  yakalanan_t          yakala_q, yakala_d;
  logic                yaz_gecerli_q, yaz_gecerli_d;
  logic [4:0]          yaz_adres_q, yaz_adres_d;
  logic [VERI_BIT-1:0] yaz_veri_q, yaz_veri_d;
  logic                hata_q, hata_d;
  logic                emekli_q, emekli_d;
  logic [SAYAC_BIT-1:0] sayac_q, sayac_d;

  // While waiting, the aligner works on the captured load; otherwise on the live uop
  logic [2:0]          hiz_tur;
  logic [1:0]          hiz_lsb;
  logic [VERI_BIT-1:0] hiz_sonuc;
  logic                hiz_hizasiz;

  assign hiz_tur = (durum_q == VERI_BEKLE) ? yakala_q.tur : uop_tur;
  assign hiz_lsb = (durum_q == VERI_BEKLE) ? yakala_q.lsb : uop_lsb;

  geri_yaz_yukleme_hizalayici u_hizalayici (
    .kelime_i  (l1v_veri_i),
    .tur_i     (hiz_tur),
    .lsb_i     (hiz_lsb),
    .sonuc_o   (hiz_sonuc),
    .hizasiz_o (hiz_hizasiz)
  );

  assign l1v_veri_hazir_o = (durum_q == VERI_BEKLE) ||
                            ((durum_q == BOSTA) && uop_valid && uop_oku);
  assign duraklat_o       = (durum_q == VERI_BEKLE);

  logic                tamam;
  logic [4:0]          son_rd;
  logic                son_rd_yaz;
  logic [VERI_BIT-1:0] son_veri;
  logic                son_hizasiz;

  // Next-state, completion decode and output-register next values
  always_comb begin
    durum_d       = durum_q;
    yakala_d      = yakala_q;
    yaz_gecerli_d = LOW;
    hata_d        = LOW;
    emekli_d      = LOW;
    yaz_adres_d   = yaz_adres_q;
    yaz_veri_d    = yaz_veri_q;
    sayac_d       = sayac_q;
    tamam         = LOW;
    son_rd        = uop_rd;
    son_rd_yaz    = uop_rd_yaz;
    son_veri      = uop_deger;
    son_hizasiz   = LOW;

    case (durum_q)
      BOSTA: begin
        if (uop_valid) begin
          if (!uop_oku) begin
            tamam = HIGH;
          end else if (l1v_veri_gecerli_i) begin
            tamam       = HIGH;
            son_veri    = hiz_sonuc;
            son_hizasiz = hiz_hizasiz;
          end else begin
            yakala_d = '{rd: uop_rd, rd_yaz: uop_rd_yaz, tur: uop_tur, lsb: uop_lsb};
            durum_d  = VERI_BEKLE;
          end
        end
      end
      VERI_BEKLE: begin
        if (l1v_veri_gecerli_i) begin
          tamam       = HIGH;
          son_rd      = yakala_q.rd;
          son_rd_yaz  = yakala_q.rd_yaz;
          son_veri    = hiz_sonuc;
          son_hizasiz = hiz_hizasiz;
          durum_d     = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase

    // Address/data only move on a real register write so they keep the last written value
    if (tamam) begin
      yaz_gecerli_d = son_rd_yaz && (son_rd != 5'd0) && !son_hizasiz;
      hata_d        = son_hizasiz;
      emekli_d      = HIGH;
      sayac_d       = sayac_q + SAYAC_BIT'(1);
      if (yaz_gecerli_d) begin
        yaz_adres_d = son_rd;
        yaz_veri_d  = son_veri;
      end
    end
  end

  // State, captured load and output registers; reset drops any pending load
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q       <= BOSTA;
      yakala_q      <= '0;
      yaz_gecerli_q <= LOW;
      yaz_adres_q   <= '0;
      yaz_veri_q    <= '0;
      hata_q        <= LOW;
      emekli_q      <= LOW;
      sayac_q       <= '0;
    end else begin
      durum_q       <= durum_d;
      yakala_q      <= yakala_d;
      yaz_gecerli_q <= yaz_gecerli_d;
      yaz_adres_q   <= yaz_adres_d;
      yaz_veri_q    <= yaz_veri_d;
      hata_q        <= hata_d;
      emekli_q      <= emekli_d;
      sayac_q       <= sayac_d;
    end
  end

  assign yaz_gecerli_o  = yaz_gecerli_q;
  assign yaz_adres_o    = yaz_adres_q;
  assign yaz_veri_o     = yaz_veri_q;
  assign hata_o         = hata_q;
  assign emekli_o       = emekli_q;
  assign emekli_sayac_o = sayac_q;

endmodule

// File: tb/tb_geri_yaz.sv
// tb/tb_geri_yaz.sv - directed self-checking bench for the writeback stage
module tb_geri_yaz;
  import geri_yaz_pkg::*;

  logic                clk = 1'b0;
  logic                rstn;
  logic [UOP_BIT-1:0]  uop;
  logic [31:0]         l1_veri;
  logic                l1_gecerli;

  logic        hazir, duraklat, yaz_gecerli, hata, emekli;
  logic [4:0]  yaz_adres;
  logic [31:0] yaz_veri;
  logic [63:0] sayac;

  logic        k_hazir, k_duraklat, k_yaz_gecerli, k_hata, k_emekli;
  logic [4:0]  k_yaz_adres;
  logic [31:0] k_yaz_veri;
  logic [3:0]  k_sayac;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  geri_yaz #(.SAYAC_BIT(64)) dut (
    .clk_i(clk), .rstn_i(rstn), .bellek_uop_i(uop), .l1v_veri_i(l1_veri),
    .l1v_veri_gecerli_i(l1_gecerli), .l1v_veri_hazir_o(hazir), .duraklat_o(duraklat),
    .yaz_gecerli_o(yaz_gecerli), .yaz_adres_o(yaz_adres), .yaz_veri_o(yaz_veri),
    .hata_o(hata), .emekli_o(emekli), .emekli_sayac_o(sayac)
  );

  geri_yaz #(.SAYAC_BIT(4)) dut_k (
    .clk_i(clk), .rstn_i(rstn), .bellek_uop_i(uop), .l1v_veri_i(l1_veri),
    .l1v_veri_gecerli_i(l1_gecerli), .l1v_veri_hazir_o(k_hazir), .duraklat_o(k_duraklat),
    .yaz_gecerli_o(k_yaz_gecerli), .yaz_adres_o(k_yaz_adres), .yaz_veri_o(k_yaz_veri),
    .hata_o(k_hata), .emekli_o(k_emekli), .emekli_sayac_o(k_sayac)
  );

  function automatic logic [UOP_BIT-1:0] mk(input logic v, input logic [4:0] rd, input logic ry,
      input logic oku, input logic [2:0] tur, input logic [1:0] lsb, input logic [31:0] d);
    logic [UOP_BIT-1:0] u;
    u = '0;
    u[UOP_VALID] = v;
    u[UOP_RD_MSB:UOP_RD_LSB] = rd;
    u[UOP_RD_YAZ] = ry;
    u[UOP_BEL_OKU] = oku;
    u[UOP_TUR_MSB:UOP_TUR_LSB] = tur;
    u[UOP_LSB_MSB:UOP_LSB_LSB] = lsb;
    u[UOP_DEGER_MSB:UOP_DEGER_LSB] = d;
    return u;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; uop = '0; l1_veri = '0; l1_gecerli = 1'b0;
    #2;
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL rst_yaz got %b exp 0", yaz_gecerli); end
    checks++; if (yaz_adres !== 5'd0) begin errors++; $display("FAIL rst_adres got %0d exp 0", yaz_adres); end
    checks++; if (yaz_veri !== 32'd0) begin errors++; $display("FAIL rst_veri got %h exp 0", yaz_veri); end
    checks++; if (hata !== 1'b0) begin errors++; $display("FAIL rst_hata got %b exp 0", hata); end
    checks++; if (emekli !== 1'b0) begin errors++; $display("FAIL rst_emekli got %b exp 0", emekli); end
    checks++; if (sayac !== 64'd0) begin errors++; $display("FAIL rst_sayac got %0d exp 0", sayac); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL rst_duraklat got %b exp 0", duraklat); end
    checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL rst_hazir got %b exp 0", hazir); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_alu();
    // Read data offered while hazir=0 must not influence a non-load
    uop = mk(1, 5'd5, 1, 0, 3'b000, 2'd0, 32'h12345678);
    l1_gecerli = 1'b1; l1_veri = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL alu_hazir got %b exp 0", hazir); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL alu_duraklat got %b exp 0", duraklat); end
    tick();
    uop = '0; l1_gecerli = 1'b0;
    checks++; if (yaz_gecerli !== 1'b1) begin errors++; $display("FAIL alu_yaz got %b exp 1", yaz_gecerli); end
    checks++; if (yaz_adres !== 5'd5) begin errors++; $display("FAIL alu_adres got %0d exp 5", yaz_adres); end
    checks++; if (yaz_veri !== 32'h12345678) begin errors++; $display("FAIL alu_veri got %h exp 12345678", yaz_veri); end
    checks++; if (emekli !== 1'b1) begin errors++; $display("FAIL alu_emekli got %b exp 1", emekli); end
    checks++; if (sayac !== 64'd1) begin errors++; $display("FAIL alu_sayac got %0d exp 1", sayac); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL alu_duraklat2 got %b exp 0", duraklat); end
    tick();
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL alu_yaz_drop got %b exp 0", yaz_gecerli); end
    checks++; if (emekli !== 1'b0) begin errors++; $display("FAIL alu_emekli_drop got %b exp 0", emekli); end
    checks++; if (yaz_veri !== 32'h12345678) begin errors++; $display("FAIL alu_veri_hold got %h exp 12345678", yaz_veri); end
  endtask

  task automatic test_back_to_back_load();
    uop = mk(1, 5'd7, 1, 1, TUR_LB, 2'd2, 32'h0);
    l1_gecerli = 1'b1; l1_veri = 32'h80FF1234;
    @(negedge clk);
    checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL lb_hazir got %b exp 1", hazir); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL lb_duraklat got %b exp 0", duraklat); end
    tick();
    uop = mk(1, 5'd7, 1, 1, TUR_LBU, 2'd2, 32'h0);
    checks++; if (yaz_veri !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_veri got %h exp ffffffff", yaz_veri); end
    checks++; if (yaz_adres !== 5'd7) begin errors++; $display("FAIL lb_adres got %0d exp 7", yaz_adres); end
    checks++; if (sayac !== 64'd2) begin errors++; $display("FAIL lb_sayac got %0d exp 2", sayac); end
    @(negedge clk);
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL lbu_duraklat got %b exp 0", duraklat); end
    tick();
    uop = '0; l1_gecerli = 1'b0;
    checks++; if (yaz_veri !== 32'h000000FF) begin errors++; $display("FAIL lbu_veri got %h exp 000000ff", yaz_veri); end
    checks++; if (yaz_gecerli !== 1'b1) begin errors++; $display("FAIL lbu_yaz got %b exp 1", yaz_gecerli); end
    checks++; if (sayac !== 64'd3) begin errors++; $display("FAIL lbu_sayac got %0d exp 3", sayac); end
  endtask

  task automatic test_load_wait();
    int stalls;
    uop = mk(1, 5'd9, 1, 1, TUR_LH, 2'd2, 32'h0);
    l1_gecerli = 1'b0;
    @(negedge clk);
    checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL lh_hazir0 got %b exp 1", hazir); end
    tick();
    // Next uop waits upstream while the load is outstanding
    uop = mk(1, 5'd10, 1, 0, 3'b000, 2'd0, 32'h000000A5);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin l1_gecerli = 1'b1; l1_veri = 32'h80010000; end
      @(negedge clk);
      if (duraklat === 1'b1) stalls++;
      checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL lh_hazir_wait%0d got %b exp 1", i, hazir); end
      checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL lh_yaz_wait%0d got %b exp 0", i, yaz_gecerli); end
      tick();
    end
    l1_gecerli = 1'b0;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL lh_stall_cycles got %0d exp 4", stalls); end
    checks++; if (yaz_gecerli !== 1'b1) begin errors++; $display("FAIL lh_yaz got %b exp 1", yaz_gecerli); end
    checks++; if (yaz_adres !== 5'd9) begin errors++; $display("FAIL lh_adres got %0d exp 9", yaz_adres); end
    checks++; if (yaz_veri !== 32'hFFFF8001) begin errors++; $display("FAIL lh_veri got %h exp ffff8001", yaz_veri); end
    checks++; if (sayac !== 64'd4) begin errors++; $display("FAIL lh_sayac got %0d exp 4", sayac); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL lh_duraklat_end got %b exp 0", duraklat); end
    tick();
    uop = '0;
    checks++; if (yaz_adres !== 5'd10) begin errors++; $display("FAIL held_adres got %0d exp 10", yaz_adres); end
    checks++; if (yaz_veri !== 32'h000000A5) begin errors++; $display("FAIL held_veri got %h exp 000000a5", yaz_veri); end
    checks++; if (sayac !== 64'd5) begin errors++; $display("FAIL held_sayac got %0d exp 5", sayac); end
  endtask

  task automatic test_rd0();
    uop = mk(1, 5'd0, 1, 1, TUR_LW, 2'd0, 32'h0);
    l1_gecerli = 1'b1; l1_veri = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL rd0_hazir got %b exp 1", hazir); end
    tick();
    uop = '0; l1_gecerli = 1'b0;
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL rd0_yaz got %b exp 0", yaz_gecerli); end
    checks++; if (emekli !== 1'b1) begin errors++; $display("FAIL rd0_emekli got %b exp 1", emekli); end
    checks++; if (sayac !== 64'd6) begin errors++; $display("FAIL rd0_sayac got %0d exp 6", sayac); end
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL rd0_duraklat got %b exp 0", duraklat); end
  endtask

  task automatic test_misaligned();
    uop = mk(1, 5'd3, 1, 1, TUR_LW, 2'd1, 32'h0);
    l1_gecerli = 1'b1; l1_veri = 32'h11223344;
    @(negedge clk);
    checks++; if (hazir !== 1'b1) begin errors++; $display("FAIL mis_lw_hazir got %b exp 1", hazir); end
    tick();
    uop = mk(1, 5'd3, 1, 1, TUR_LHU, 2'd1, 32'h0);
    checks++; if (hata !== 1'b1) begin errors++; $display("FAIL mis_lw_hata got %b exp 1", hata); end
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL mis_lw_yaz got %b exp 0", yaz_gecerli); end
    checks++; if (emekli !== 1'b1) begin errors++; $display("FAIL mis_lw_emekli got %b exp 1", emekli); end
    checks++; if (sayac !== 64'd7) begin errors++; $display("FAIL mis_lw_sayac got %0d exp 7", sayac); end
    tick();
    uop = '0; l1_gecerli = 1'b0;
    checks++; if (hata !== 1'b1) begin errors++; $display("FAIL mis_lhu_hata got %b exp 1", hata); end
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL mis_lhu_yaz got %b exp 0", yaz_gecerli); end
    checks++; if (sayac !== 64'd8) begin errors++; $display("FAIL mis_lhu_sayac got %0d exp 8", sayac); end
    tick();
    checks++; if (hata !== 1'b0) begin errors++; $display("FAIL mis_hata_drop got %b exp 0", hata); end
    checks++; if (emekli !== 1'b0) begin errors++; $display("FAIL mis_emekli_drop got %b exp 0", emekli); end
  endtask

  task automatic test_reset_mid_wait();
    uop = mk(1, 5'd4, 1, 1, TUR_LW, 2'd0, 32'h0);
    l1_gecerli = 1'b0;
    tick();
    uop = '0;
    @(negedge clk);
    checks++; if (duraklat !== 1'b1) begin errors++; $display("FAIL rm_duraklat_pre got %b exp 1", duraklat); end
    rstn = 1'b0;
    #1;
    checks++; if (duraklat !== 1'b0) begin errors++; $display("FAIL rm_duraklat got %b exp 0", duraklat); end
    checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL rm_hazir got %b exp 0", hazir); end
    checks++; if (sayac !== 64'd0) begin errors++; $display("FAIL rm_sayac got %0d exp 0", sayac); end
    checks++; if (yaz_veri !== 32'd0) begin errors++; $display("FAIL rm_veri got %h exp 0", yaz_veri); end
    checks++; if (yaz_adres !== 5'd0) begin errors++; $display("FAIL rm_adres got %0d exp 0", yaz_adres); end
    tick();
    rstn = 1'b1;
    l1_gecerli = 1'b1; l1_veri = 32'h12345678;
    @(negedge clk);
    checks++; if (hazir !== 1'b0) begin errors++; $display("FAIL rm_hazir_after got %b exp 0", hazir); end
    tick();
    l1_gecerli = 1'b0;
    checks++; if (yaz_gecerli !== 1'b0) begin errors++; $display("FAIL rm_yaz got %b exp 0", yaz_gecerli); end
    checks++; if (emekli !== 1'b0) begin errors++; $display("FAIL rm_emekli got %b exp 0", emekli); end
    checks++; if (sayac !== 64'd0) begin errors++; $display("FAIL rm_sayac_after got %0d exp 0", sayac); end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 15; i++) begin
      uop = mk(1, 5'd1, 1, 0, 3'b000, 2'd0, 32'(i));
      tick();
    end
    checks++; if (k_sayac !== 4'hF) begin errors++; $display("FAIL wrap_pre got %h exp f", k_sayac); end
    checks++; if (sayac !== 64'd15) begin errors++; $display("FAIL wrap_big_pre got %0d exp 15", sayac); end
    tick();
    uop = '0;
    checks++; if (k_sayac !== 4'h0) begin errors++; $display("FAIL wrap got %h exp 0", k_sayac); end
    checks++; if (k_emekli !== 1'b1) begin errors++; $display("FAIL wrap_emekli got %b exp 1", k_emekli); end
    checks++; if (sayac !== 64'd16) begin errors++; $display("FAIL wrap_big got %0d exp 16", sayac); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back_load();
    test_load_wait();
    test_rd0();
    test_misaligned();
    test_reset_mid_wait();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
